mc_ctrl: RTL and testbench

- Multicycle main controller for the RV32I core. It sequences one shared ALU, the immediate extender, the register file and a single unified memory port.
- It decodes the latched instruction fields and drives every datapath select and strobe state by state, including the immediate extender's imm_src.
- Memory accesses use a req/ready handshake so the UART-side memory can stall the core.

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle main controller and the RV32I datapath.
// The master side is the controller; the slave side is the datapath and memory port.
interface mc_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] imm_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] result_src;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  opcode, funct3, funct7b5, zero, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_control, result_src,
             instr_done, illegal
   );

   modport slave (
      output opcode, funct3, funct7b5, zero, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             imm_src, alu_src_a, alu_src_b, alu_control, result_src,
             instr_done, illegal
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle RV32I main controller: sequences shared ALU, immediate extender,
// register file and a unified req/ready memory port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 into PC when memory completes
// DECODE   | instruction latched; precompute branch target oldPC+immB
// MEMADR   | rs1 + imm (I or S) into the ALU out register
// MEMREAD  | load access, held until mem_ready
// MEMWB    | write read data to rd, retire
// MEMWRITE | store access, retires in the cycle mem_ready is seen
// EXECR    | rs1 op rs2
// EXECI    | rs1 op immI
// ALUWB    | write ALU out register to rd, retire
// BEQ      | rs1 - rs2, load branch target into PC when zero, retire
// TRAP     | unsupported opcode parked; only reset leaves
module mc_ctrl #(
   parameter bit RESET_TRAP = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   mc_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_TRAP     = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t state;
   logic   illegal_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
            S_DECODE: begin
               case (bus.opcode)
                  OP_LOAD, OP_STORE: state <= S_MEMADR;
                  OP_RTYPE:          state <= S_EXECR;
                  OP_ITYPE:          state <= S_EXECI;
                  OP_BEQ:            state <= S_BEQ;
                  default: begin
                     if (RESET_TRAP) begin
                        state     <= S_TRAP;
                        illegal_q <= 1'b1;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               endcase
            end
            S_MEMADR:   state <= bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
            S_EXECR:    state <= S_ALUWB;
            S_EXECI:    state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BEQ:      state <= S_FETCH;
            S_TRAP:     state <= S_TRAP;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // funct7b5 only selects sub for register-register ops (opcode[5]=1).
   logic [2:0] alu_dec;
   always_comb begin
      alu_dec = ALU_ADD;
      case (bus.funct3)
         3'b000:  alu_dec = (bus.opcode[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      bus.mem_req     = 1'b0;
      bus.mem_write   = 1'b0;
      bus.adr_src     = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.imm_src     = 2'b00;
      bus.alu_src_a   = 2'b00;
      bus.alu_src_b   = 2'b00;
      bus.alu_control = ALU_ADD;
      bus.result_src  = 2'b00;
      bus.instr_done  = 1'b0;
      bus.illegal     = 1'b0;
      if (rst_n) begin
         bus.illegal = illegal_q;
         case (state)
            S_FETCH: begin
               bus.mem_req    = 1'b1;
               bus.alu_src_b  = 2'b10;
               bus.result_src = 2'b10;
               bus.ir_write   = bus.mem_ready;
               bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
               bus.alu_src_a = 2'b01;
               bus.alu_src_b = 2'b01;
               bus.imm_src   = 2'b10;
            end
            S_MEMADR: begin
               bus.alu_src_a = 2'b10;
               bus.alu_src_b = 2'b01;
               bus.imm_src   = bus.opcode[5] ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
               bus.mem_req = 1'b1;
               bus.adr_src = 1'b1;
            end
            S_MEMWB: begin
               bus.result_src = 2'b01;
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
               bus.mem_req    = 1'b1;
               bus.mem_write  = 1'b1;
               bus.adr_src    = 1'b1;
               bus.instr_done = bus.mem_ready;
            end
            S_EXECR: begin
               bus.alu_src_a   = 2'b10;
               bus.alu_control = alu_dec;
            end
            S_EXECI: begin
               bus.alu_src_a   = 2'b10;
               bus.alu_src_b   = 2'b01;
               bus.alu_control = alu_dec;
            end
            S_ALUWB: begin
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
            end
            S_BEQ: begin
               bus.alu_src_a   = 2'b10;
               bus.alu_control = ALU_SUB;
               bus.pc_write    = bus.zero;
               bus.instr_done  = 1'b1;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven check of mc_ctrl: one instance traps on bad opcodes, the other
// treats them as NOPs; both share the same stimulus.
module tb_mc_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] imm_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] result_src;
      logic       instr_done;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic       rst_n;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      logic       rdy;
      outs_t      exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mc_ctrl_if bus_t ();
   mc_ctrl_if bus_n ();

   assign bus_t.opcode = opcode;    assign bus_n.opcode = opcode;
   assign bus_t.funct3 = funct3;    assign bus_n.funct3 = funct3;
   assign bus_t.funct7b5 = funct7b5; assign bus_n.funct7b5 = funct7b5;
   assign bus_t.zero = zero;        assign bus_n.zero = zero;
   assign bus_t.mem_ready = mem_ready; assign bus_n.mem_ready = mem_ready;

   mc_ctrl #(.RESET_TRAP(1'b1)) dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));
   mc_ctrl #(.RESET_TRAP(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

   outs_t act_t, act_n;
   assign act_t = {bus_t.mem_req, bus_t.mem_write, bus_t.adr_src, bus_t.ir_write,
                   bus_t.pc_write, bus_t.reg_write, bus_t.imm_src, bus_t.alu_src_a,
                   bus_t.alu_src_b, bus_t.alu_control, bus_t.result_src,
                   bus_t.instr_done, bus_t.illegal};
   assign act_n = {bus_n.mem_req, bus_n.mem_write, bus_n.adr_src, bus_n.ir_write,
                   bus_n.pc_write, bus_n.reg_write, bus_n.imm_src, bus_n.alu_src_a,
                   bus_n.alu_src_b, bus_n.alu_control, bus_n.result_src,
                   bus_n.instr_done, bus_n.illegal};

   function automatic outs_t o(input logic req, input logic wr, input logic adr,
                               input logic irw, input logic pcw, input logic rw,
                               input logic [1:0] imm, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [2:0] alu,
                               input logic [1:0] rs, input logic done,
                               input logic ill);
      return {req, wr, adr, irw, pcw, rw, imm, sa, sb, alu, rs, done, ill};
   endfunction

   // Expected outputs per state, hand-derived from the state descriptions.
   function automatic outs_t e_fetch(input logic r);  return o(1,0,0,r,r,0,2'd0,2'd0,2'd2,3'd0,2'd2,0,0); endfunction
   function automatic outs_t e_decode();              return o(0,0,0,0,0,0,2'd2,2'd1,2'd1,3'd0,2'd0,0,0); endfunction
   function automatic outs_t e_memadr(input logic s); return o(0,0,0,0,0,0,{1'b0,s},2'd2,2'd1,3'd0,2'd0,0,0); endfunction
   function automatic outs_t e_memread();             return o(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0); endfunction
   function automatic outs_t e_memwb();               return o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd1,1,0); endfunction
   function automatic outs_t e_memwrite(input logic r); return o(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,r,0); endfunction
   function automatic outs_t e_execr(input logic [2:0] a); return o(0,0,0,0,0,0,2'd0,2'd2,2'd0,a,2'd0,0,0); endfunction
   function automatic outs_t e_execi(input logic [2:0] a); return o(0,0,0,0,0,0,2'd0,2'd2,2'd1,a,2'd0,0,0); endfunction
   function automatic outs_t e_aluwb();               return o(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd0,1,0); endfunction
   function automatic outs_t e_beq(input logic z);    return o(0,0,0,0,z,0,2'd0,2'd2,2'd0,3'd1,2'd0,1,0); endfunction
   function automatic outs_t e_trap();                return o(0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,1); endfunction
   function automatic outs_t e_zero();                return o(0,0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0); endfunction

   vec_t vecs[$];

   task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic z, input logic rdy, input outs_t e);
      vec_t v;
      v.rst_n = r; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111;

   initial begin
      // reset with mem_ready high: everything quiet
      add(0, LW, 3'd0, 0, 0, 1, e_zero());
      add(0, LW, 3'd0, 0, 0, 1, e_zero());
      // lw with one wait cycle in MEMREAD
      add(1, LW, 3'd2, 0, 0, 1, e_fetch(1));
      add(1, LW, 3'd2, 0, 0, 1, e_decode());
      add(1, LW, 3'd2, 0, 0, 1, e_memadr(0));
      add(1, LW, 3'd2, 0, 0, 0, e_memread());
      add(1, LW, 3'd2, 0, 0, 1, e_memread());
      add(1, LW, 3'd2, 0, 0, 1, e_memwb());
      // sw with three wait cycles in MEMWRITE
      add(1, SW, 3'd2, 0, 0, 1, e_fetch(1));
      add(1, SW, 3'd2, 0, 0, 1, e_decode());
      add(1, SW, 3'd2, 0, 0, 1, e_memadr(1));
      add(1, SW, 3'd2, 0, 0, 0, e_memwrite(0));
      add(1, SW, 3'd2, 0, 0, 0, e_memwrite(0));
      add(1, SW, 3'd2, 0, 0, 0, e_memwrite(0));
      add(1, SW, 3'd2, 0, 0, 1, e_memwrite(1));
      // R-type sub, with a stalled fetch first
      add(1, RT, 3'd0, 1, 0, 0, e_fetch(0));
      add(1, RT, 3'd0, 1, 0, 1, e_fetch(1));
      add(1, RT, 3'd0, 1, 0, 1, e_decode());
      add(1, RT, 3'd0, 1, 0, 1, e_execr(3'b001));
      add(1, RT, 3'd0, 1, 0, 1, e_aluwb());
      // addi with funct7b5=1 stays add
      add(1, IT, 3'd0, 1, 0, 1, e_fetch(1));
      add(1, IT, 3'd0, 1, 0, 1, e_decode());
      add(1, IT, 3'd0, 1, 0, 1, e_execi(3'b000));
      add(1, IT, 3'd0, 1, 0, 1, e_aluwb());
      // R-type and
      add(1, RT, 3'd7, 0, 0, 1, e_fetch(1));
      add(1, RT, 3'd7, 0, 0, 1, e_decode());
      add(1, RT, 3'd7, 0, 0, 1, e_execr(3'b010));
      add(1, RT, 3'd7, 0, 0, 1, e_aluwb());
      // ori (I-type or), slti
      add(1, IT, 3'd6, 0, 0, 1, e_fetch(1));
      add(1, IT, 3'd6, 0, 0, 1, e_decode());
      add(1, IT, 3'd6, 0, 0, 1, e_execi(3'b011));
      add(1, IT, 3'd6, 0, 0, 1, e_aluwb());
      add(1, IT, 3'd2, 0, 0, 1, e_fetch(1));
      add(1, IT, 3'd2, 0, 0, 1, e_decode());
      add(1, IT, 3'd2, 0, 0, 1, e_execi(3'b101));
      add(1, IT, 3'd2, 0, 0, 1, e_aluwb());
      // beq taken / not taken
      add(1, BQ, 3'd0, 0, 1, 1, e_fetch(1));
      add(1, BQ, 3'd0, 0, 1, 1, e_decode());
      add(1, BQ, 3'd0, 0, 1, 1, e_beq(1));
      add(1, BQ, 3'd0, 0, 0, 1, e_fetch(1));
      add(1, BQ, 3'd0, 0, 0, 1, e_decode());
      add(1, BQ, 3'd0, 0, 0, 1, e_beq(0));
      // unsupported opcode parks the trapping instance
      add(1, BAD, 3'd0, 0, 0, 1, e_fetch(1));
      add(1, BAD, 3'd0, 0, 0, 1, e_decode());
      add(1, BAD, 3'd0, 0, 0, 1, e_trap());

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; opcode = vecs[i].op; funct3 = vecs[i].f3;
         funct7b5 = vecs[i].f7; zero = vecs[i].z; mem_ready = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d", i), act_t, vecs[i].exp);
      end

      // TRAP holds illegal for 10 cycles regardless of mem_ready
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mem_ready = i[0];
         #1;
         chk($sformatf("trap_hold%0d", i), act_t, e_trap());
      end

      // reset clears illegal and returns both instances to FETCH
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b1;
      #1;
      chk("trap_in_reset", act_t, e_zero());
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("trap_after_reset", act_t, e_fetch(1));
      chk("nop_after_reset", act_n, e_fetch(1));

      // the non-trapping instance treats the bad opcode as a NOP
      @(negedge clk);
      #1;
      chk("nop_decode", act_n, e_decode());
      @(negedge clk);
      #1;
      chk("nop_back_fetch", act_n, e_fetch(1));
      chk("trap_again", act_t, e_trap());
      @(negedge clk);
      #1;
      chk("nop_decode2", act_n, e_decode());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
